// File: rtl/gerencia_pc_ctx_if.sv
// Bus between the datapath/kernel (master) and the PC/context manager (slave).
interface gerencia_pc_ctx_if #(
  parameter int PC_W     = 32,
  parameter int NUM_PROC = 4,
  parameter int ID_W     = 2
);
  logic                HALT;
  logic                stall;
  logic [PC_W-1:0]     novoPC;
  logic                sw_req;
  logic [ID_W-1:0]     sw_id;
  logic [PC_W-1:0]     sw_pc;
  logic [PC_W-1:0]     atualPC;
  logic [ID_W-1:0]     id_proc;
  logic                sw_busy;
  logic                sw_done;
  logic                sw_err;
  logic [NUM_PROC-1:0] ctx_valid;
  logic                pc_fault;

  modport master (
    output HALT, stall, novoPC, sw_req, sw_id, sw_pc,
    input  atualPC, id_proc, sw_busy, sw_done, sw_err, ctx_valid, pc_fault
  );

  modport slave (
    input  HALT, stall, novoPC, sw_req, sw_id, sw_pc,
    output atualPC, id_proc, sw_busy, sw_done, sw_err, ctx_valid, pc_fault
  );
endinterface

// File: rtl/gerencia_pc_ctx.sv
// Multi-context PC manager: live PC, running process ID, kernel-driven context switches.
// Optional per-process PC region check enabled by defining PC_BOUNDS_EN.
module gerencia_pc_ctx #(
  parameter int PC_W      = 32,
  parameter int NUM_PROC  = 4,
  parameter int ID_W      = 2,
  parameter int KERNEL_PC = 0,
  parameter int HALT_PC   = 46,
  parameter int REGION_SZ = 256,
  parameter int FAULT_PC  = 44
) (
  input  logic                clk,
  input  logic                reset,
  gerencia_pc_ctx_if.slave    bus
);

  typedef enum logic {RUN, LOAD} state_t;

  localparam logic [PC_W-1:0] KernelPc = PC_W'(KERNEL_PC);
  localparam logic [PC_W-1:0] HaltPc   = PC_W'(HALT_PC);
  localparam logic [PC_W-1:0] FaultPc  = PC_W'(FAULT_PC);
  localparam logic [ID_W:0]   NumProcL = (ID_W+1)'(NUM_PROC);
  localparam int              EW       = PC_W + ID_W + 1;

`ifdef PC_BOUNDS_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  state_t              stateQ, stateNext;
  logic [PC_W-1:0]     pcQ, pcNext;
  logic [ID_W-1:0]     idQ, idNext;
  logic [NUM_PROC-1:0] validQ, validNext;
  logic [ID_W-1:0]     tgtQ, tgtNext;
  logic [PC_W-1:0]     swPcQ, swPcNext;
  logic                doneQ, doneNext;
  logic                errQ, errNext;
  logic                faultQ, faultNext;
  logic                ctx0We;
  logic [PC_W-1:0]     ctxPc [NUM_PROC];

  logic                swAccept;
  logic                boundsFault;
  logic [EW-1:0]       regionLo, regionHi, pcExt;

  // A user process may only execute inside [id*REGION_SZ, (id+1)*REGION_SZ).
  always_comb begin
    regionLo    = EW'(idQ) * EW'(REGION_SZ);
    regionHi    = regionLo + EW'(REGION_SZ);
    pcExt       = EW'(bus.novoPC);
    boundsFault = BoundsEn && (idQ != '0) && ((pcExt < regionLo) || (pcExt >= regionHi));
  end

  assign swAccept = bus.sw_req && (idQ == '0) && (bus.sw_id != '0) &&
                    ({1'b0, bus.sw_id} < NumProcL);

  // NOTE: combinational blocks use blocking '=' and sequential blocks use '<=';
  // every output gets a default first so no path leaves a latch behind.
  always_comb begin
    stateNext = stateQ;
    pcNext    = pcQ;
    idNext    = idQ;
    validNext = validQ;
    tgtNext   = tgtQ;
    swPcNext  = swPcQ;
    doneNext  = 1'b0;
    errNext   = 1'b0;
    faultNext = 1'b0;
    ctx0We    = 1'b0;

    unique case (stateQ)
      RUN: begin
        if (bus.HALT) begin
          if (idQ == '0) begin
            pcNext = KernelPc;
          end else begin
            pcNext         = HaltPc;
            idNext         = '0;
            validNext[idQ] = 1'b0;
          end
        end else if (boundsFault) begin
          pcNext         = FaultPc;
          idNext         = '0;
          validNext[idQ] = 1'b0;
          faultNext      = 1'b1;
          errNext        = bus.sw_req;
        end else if (swAccept) begin
          ctx0We       = 1'b1;
          validNext[0] = 1'b1;
          tgtNext      = bus.sw_id;
          swPcNext     = bus.sw_pc;
          stateNext    = LOAD;
        end else begin
          errNext = bus.sw_req;
          if (!bus.stall) pcNext = bus.novoPC;
        end
      end
      LOAD: begin
        // HALT, stall and sw_req are deliberately ignored for this one cycle.
        pcNext    = validQ[tgtQ] ? ctxPc[tgtQ] : swPcQ;
        idNext    = tgtQ;
        doneNext  = 1'b1;
        stateNext = RUN;
      end
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= RUN;
      pcQ    <= KernelPc;
      idQ    <= '0;
      validQ <= '0;
      tgtQ   <= '0;
      swPcQ  <= '0;
      doneQ  <= 1'b0;
      errQ   <= 1'b0;
      faultQ <= 1'b0;
    end else begin
      stateQ <= stateNext;
      pcQ    <= pcNext;
      idQ    <= idNext;
      validQ <= validNext;
      tgtQ   <= tgtNext;
      swPcQ  <= swPcNext;
      doneQ  <= doneNext;
      errQ   <= errNext;
      faultQ <= faultNext;
    end
  end

  // NOTE: the context PC store is cleared on reset because the block's reset
  // state is defined to include all-zero saved PCs, not just the valid flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PROC; i++) ctxPc[i] <= '0;
    end else if (ctx0We) begin
      ctxPc[0] <= bus.novoPC;
    end
  end

  assign bus.atualPC   = pcQ;
  assign bus.id_proc   = idQ;
  assign bus.sw_busy   = (stateQ == LOAD);
  assign bus.sw_done   = doneQ;
  assign bus.sw_err    = errQ;
  assign bus.ctx_valid = validQ;
  assign bus.pc_fault  = faultQ;

endmodule

// File: tb/tb_gerencia_pc_ctx.sv
// Directed self-checking bench for gerencia_pc_ctx (NUM_PROC=3 to reach sw_id>=NUM_PROC).
module tb_gerencia_pc_ctx;
  localparam int PC_W     = 32;
  localparam int NUM_PROC = 3;
  localparam int ID_W     = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  gerencia_pc_ctx_if #(.PC_W(PC_W), .NUM_PROC(NUM_PROC), .ID_W(ID_W)) bus ();

  gerencia_pc_ctx #(
    .PC_W(PC_W), .NUM_PROC(NUM_PROC), .ID_W(ID_W),
    .KERNEL_PC(0), .HALT_PC(46), .REGION_SZ(256), .FAULT_PC(44)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.HALT = 1'b0; bus.stall = 1'b0; bus.novoPC = '0;
    bus.sw_req = 1'b0; bus.sw_id = '0; bus.sw_pc = '0;
    step(); step();
    check("rst_pc",    bus.atualPC, 0);
    check("rst_id",    32'(bus.id_proc), 0);
    check("rst_valid", 32'(bus.ctx_valid), 0);
    check("rst_busy",  32'(bus.sw_busy), 0);
    check("rst_done",  32'(bus.sw_done), 0);
    check("rst_err",   32'(bus.sw_err), 0);
    check("rst_fault", 32'(bus.pc_fault), 0);

    // Plain advance
    reset = 1'b0;
    bus.novoPC = 1; step(); check("adv1", bus.atualPC, 1);
    bus.novoPC = 2; step(); check("adv2", bus.atualPC, 2);
    bus.novoPC = 3; step(); check("adv3", bus.atualPC, 3);
    check("adv_id", 32'(bus.id_proc), 0);
    check("adv_valid", 32'(bus.ctx_valid), 0);

    // Kernel switch to process 2, HALT/stall asserted during LOAD are ignored
    bus.novoPC = 10; bus.sw_req = 1'b1; bus.sw_id = 2; bus.sw_pc = 512; step();
    check("sw1_busy",  32'(bus.sw_busy), 1);
    check("sw1_hold",  bus.atualPC, 3);
    check("sw1_id0",   32'(bus.id_proc), 0);
    check("sw1_valid", 32'(bus.ctx_valid), 32'b001);
    check("sw1_nodone", 32'(bus.sw_done), 0);
    bus.sw_req = 1'b0; bus.HALT = 1'b1; bus.stall = 1'b1; bus.novoPC = 999; step();
    check("sw1_pc",   bus.atualPC, 512);
    check("sw1_id",   32'(bus.id_proc), 2);
    check("sw1_done", 32'(bus.sw_done), 1);
    check("sw1_idle", 32'(bus.sw_busy), 0);
    check("sw1_err",  32'(bus.sw_err), 0);
    bus.HALT = 1'b0; bus.stall = 1'b0; bus.novoPC = 513; step();
    check("u2_adv",   bus.atualPC, 513);
    check("done_pulse", 32'(bus.sw_done), 0);

    // Switch request from a user process is rejected
    bus.sw_req = 1'b1; bus.sw_id = 1; bus.sw_pc = 0; bus.novoPC = 514; step();
    check("uerr_err", 32'(bus.sw_err), 1);
    check("uerr_pc",  bus.atualPC, 514);
    check("uerr_id",  32'(bus.id_proc), 2);
    check("uerr_busy", 32'(bus.sw_busy), 0);
    bus.sw_req = 1'b0; bus.novoPC = 515; step();
    check("err_pulse", 32'(bus.sw_err), 0);
    check("u2_adv2",  bus.atualPC, 515);

    // Stall holds the PC while novoPC changes
    bus.stall = 1'b1; bus.novoPC = 520; step(); check("stall1", bus.atualPC, 515);
    bus.novoPC = 530; step(); check("stall2", bus.atualPC, 515);
    bus.stall = 1'b0;

    // User HALT returns to kernel at HALT_PC
    bus.HALT = 1'b1; bus.novoPC = 540; step();
    check("uhalt_pc",    bus.atualPC, 46);
    check("uhalt_id",    32'(bus.id_proc), 0);
    check("uhalt_valid", 32'(bus.ctx_valid), 32'b001);
    bus.HALT = 1'b0; bus.novoPC = 47; step(); check("k_adv", bus.atualPC, 47);

    // Kernel HALT reloads KERNEL_PC
    bus.HALT = 1'b1; bus.novoPC = 50; step();
    check("khalt_pc",    bus.atualPC, 0);
    check("khalt_id",    32'(bus.id_proc), 0);
    check("khalt_valid", 32'(bus.ctx_valid), 32'b001);
    bus.HALT = 1'b0;

    // Kernel requests with sw_id==0 and sw_id>=NUM_PROC are rejected
    bus.sw_req = 1'b1; bus.sw_id = 0; bus.novoPC = 20; step();
    check("id0_err",  32'(bus.sw_err), 1);
    check("id0_pc",   bus.atualPC, 20);
    check("id0_busy", 32'(bus.sw_busy), 0);
    bus.sw_id = 3; bus.novoPC = 21; step();
    check("idhi_err", 32'(bus.sw_err), 1);
    check("idhi_pc",  bus.atualPC, 21);
    check("idhi_id",  32'(bus.id_proc), 0);

    // Accepted request wins over stall; fresh target uses sw_pc
    bus.sw_id = 2; bus.sw_pc = 600; bus.stall = 1'b1; bus.novoPC = 48; step();
    check("sw2_busy", 32'(bus.sw_busy), 1);
    check("sw2_err",  32'(bus.sw_err), 0);
    check("sw2_hold", bus.atualPC, 21);
    bus.sw_req = 1'b0; bus.stall = 1'b0; bus.novoPC = 5; step();
    check("sw2_pc",   bus.atualPC, 600);
    check("sw2_id",   32'(bus.id_proc), 2);
    check("sw2_done", 32'(bus.sw_done), 1);
    bus.HALT = 1'b1; step();
    check("uhalt2_pc", bus.atualPC, 46);
    bus.HALT = 1'b0;

    // Switch to process 1
    bus.sw_req = 1'b1; bus.sw_id = 1; bus.sw_pc = 256; bus.novoPC = 60; step();
    bus.sw_req = 1'b0; bus.novoPC = 61; step();
    check("sw3_pc", bus.atualPC, 256);
    check("sw3_id", 32'(bus.id_proc), 1);
    bus.novoPC = 300; step(); check("u1_adv", bus.atualPC, 300);
    bus.sw_req = 1'b1; bus.sw_id = 2; bus.novoPC = 301; step();
    check("u1err_err", 32'(bus.sw_err), 1);
    check("u1err_pc",  bus.atualPC, 301);
    check("u1err_id",  32'(bus.id_proc), 1);
    bus.sw_req = 1'b0;

`ifdef PC_BOUNDS_EN
    bus.novoPC = 600; step();
    check("bf_pc",    bus.atualPC, 44);
    check("bf_id",    32'(bus.id_proc), 0);
    check("bf_fault", 32'(bus.pc_fault), 1);
    check("bf_valid", 32'(bus.ctx_valid), 32'b001);
    bus.novoPC = 601; step();
    check("bf_pulse", 32'(bus.pc_fault), 0);
    check("bf_kadv",  bus.atualPC, 601);
    bus.sw_req = 1'b1; bus.sw_id = 1; bus.sw_pc = 256; bus.novoPC = 62; step();
    bus.sw_req = 1'b0; step();
    check("sw4_id", 32'(bus.id_proc), 1);
    bus.HALT = 1'b1; bus.novoPC = 600; step();
    check("hf_pc",    bus.atualPC, 46);
    check("hf_fault", 32'(bus.pc_fault), 0);
    check("hf_id",    32'(bus.id_proc), 0);
    bus.HALT = 1'b0;
`else
    bus.novoPC = 600; step();
    check("nob_pc",    bus.atualPC, 600);
    check("nob_id",    32'(bus.id_proc), 1);
    check("nob_fault", 32'(bus.pc_fault), 0);
    bus.HALT = 1'b1; step();
    check("uhalt3_pc", bus.atualPC, 46);
    bus.HALT = 1'b0;
`endif

    // Reset during LOAD aborts the switch
    bus.sw_req = 1'b1; bus.sw_id = 2; bus.sw_pc = 700; bus.novoPC = 70; step();
    check("sw5_busy", 32'(bus.sw_busy), 1);
    bus.sw_req = 1'b0; reset = 1'b1; step();
    check("rl_pc",    bus.atualPC, 0);
    check("rl_id",    32'(bus.id_proc), 0);
    check("rl_busy",  32'(bus.sw_busy), 0);
    check("rl_done",  32'(bus.sw_done), 0);
    check("rl_valid", 32'(bus.ctx_valid), 0);
    reset = 1'b0; bus.novoPC = 7; step();
    check("rl_adv",   bus.atualPC, 7);
    check("rl_done2", 32'(bus.sw_done), 0);
    check("rl_id2",   32'(bus.id_proc), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
